cla_limb_sequencer: RTL and testbench



---
 rtl/cla_limb_sequencer_pkg.sv | 13 +
 rtl/CLA_64bit.sv | 47 ++++
 rtl/cla_limb_sequencer.sv | 100 ++++++++++
 tb/tb_cla_limb_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_limb_sequencer_pkg.sv
// Shared definitions for the wide-integer limb sequencer: limb width and
// controller state encoding.
package cla_limb_sequencer_pkg;

  localparam int LIMB_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : cla_limb_sequencer_pkg

// File: rtl/CLA_64bit.sv
// 64-bit carry-lookahead adder. Bits are grouped by four; each group forms
// its own generate/propagate so the carry between groups skips four bit
// positions at a time. Purely combinational.
module CLA_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic [63:0] g;
  logic [63:0] p;
  logic [15:0] gg;
  logic [15:0] gp;
  logic [64:0] c;

  // Bit and group generate/propagate, then group carries and in-group carries.
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop, so no latch can be inferred.
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    c  = '0;
    c[0] = cin;
    for (int j = 0; j < 16; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    for (int j = 0; j < 16; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+4] = gg[j] | (gp[j] & c[4*j]);
    end
    sum  = p ^ c[63:0];
    cout = c[64];
  end

endmodule : CLA_64bit

// File: rtl/cla_limb_sequencer.sv
// Wide add/subtract controller: streams one 64-bit limb per cycle through a
// single CLA_64bit, chaining a registered carry from limb to limb.
// Subtraction is a + ~b + 1 (operand B inverted at capture, carry seeded to 1).
module cla_limb_sequencer
  import cla_limb_sequencer_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    op_sub,
  input  logic [LIMB_W*LIMBS-1:0] a,
  input  logic [LIMB_W*LIMBS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [LIMB_W*LIMBS-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int CNT_W = $clog2(LIMBS);
  localparam int W     = LIMB_W * LIMBS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMBS - 1);

  state_t             state;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic [LIMB_W-1:0]  limb_a;
  logic [LIMB_W-1:0]  limb_b;
  logic [LIMB_W-1:0]  add_sum;
  logic               add_cout;

  assign limb_a = op_a[cnt*LIMB_W +: LIMB_W];
  assign limb_b = op_b[cnt*LIMB_W +: LIMB_W];

  CLA_64bit u_cla (
    .a    (limb_a),
    .b    (limb_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Controller: command capture, per-limb writeback and carry chaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are flops, not a memory, so resetting them is cheap and keeps a mid-operation abort fully deterministic.
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b ^ {W{op_sub}};
            carry <= op_sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sum[cnt*LIMB_W +: LIMB_W] <= add_sum;
          carry <= add_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout  <= add_cout;
            ovf   <= (limb_a[LIMB_W-1] == limb_b[LIMB_W-1]) &&
                     (add_sum[LIMB_W-1] != limb_a[LIMB_W-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : cla_limb_sequencer

// File: tb/tb_cla_limb_sequencer.sv
// Directed bench for cla_limb_sequencer with LIMBS=4 (256-bit operands).
module tb_cla_limb_sequencer;

  localparam int LIMBS = 4;
  localparam int W     = 64 * LIMBS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total;
  int bad;

  cla_limb_sequencer #(.LIMBS(LIMBS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; start is seen by the next rising edge.
  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub);
    a      = av;
    b      = bv;
    op_sub = sub;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Waits (bounded) for done; lat is the cycle index relative to acceptance.
  task automatic wait_done(input int first, output int lat, output int bcnt);
    lat  = first;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  int lat;
  int bcnt;
  int done_seen;

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a      = rand_w();
      b      = rand_w();
      start  = 1'($urandom_range(0, 1));
      op_sub = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_sum",  sum,      '0);
    check("rst_cout", W'(cout), W'(0));
    check("rst_ovf",  W'(ovf),  W'(0));
    start = 1'b0;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rst_no_done", W'(done_seen), W'(0));

    // Full-carry add: (2^256-1) + 1.
    @(negedge clk);
    drive_start({W{1'b1}}, W'(1), 1'b0);
    wait_done(1, lat, bcnt);
    check("full_lat",  W'(lat),  W'(5));
    check("full_busy", W'(bcnt), W'(4));
    check("full_sum",  sum,      '0);
    check("full_cout", W'(cout), W'(1));
    check("full_ovf",  W'(ovf),  W'(0));
    @(negedge clk);
    check("full_done_pulse", W'(done), W'(0));
    check("full_sum_hold",   sum,      '0);

    // Inter-limb carry: limb0 all ones + 1.
    @(negedge clk);
    drive_start({{192{1'b0}}, {64{1'b1}}}, W'(1), 1'b0);
    wait_done(1, lat, bcnt);
    check("ilc_lat",  W'(lat),  W'(5));
    check("ilc_sum",  sum,      W'(1) << 64);
    check("ilc_cout", W'(cout), W'(0));

    // Subtract with borrow: 5 - 7.
    @(negedge clk);
    drive_start(W'(5), W'(7), 1'b1);
    wait_done(1, lat, bcnt);
    check("sub57_sum",  sum,      ~W'(1));
    check("sub57_cout", W'(cout), W'(0));
    check("sub57_ovf",  W'(ovf),  W'(0));

    // 7 - 5.
    @(negedge clk);
    drive_start(W'(7), W'(5), 1'b1);
    wait_done(1, lat, bcnt);
    check("sub75_sum",  sum,      W'(2));
    check("sub75_cout", W'(cout), W'(1));
    check("sub75_ovf",  W'(ovf),  W'(0));

    // Signed overflow on add: (2^255-1) + 1.
    @(negedge clk);
    drive_start({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);
    wait_done(1, lat, bcnt);
    check("ovfa_sum",  sum,      W'(1) << 255);
    check("ovfa_ovf",  W'(ovf),  W'(1));
    check("ovfa_cout", W'(cout), W'(0));

    // Signed overflow on subtract: 2^255 - 1.
    @(negedge clk);
    drive_start(W'(1) << 255, W'(1), 1'b1);
    wait_done(1, lat, bcnt);
    check("ovfs_sum",  sum,      {1'b0, {(W-1){1'b1}}});
    check("ovfs_ovf",  W'(ovf),  W'(1));
    check("ovfs_cout", W'(cout), W'(1));

    // Reset in cycle 2 of RUN aborts the operation.
    @(negedge clk);
    drive_start(W'(5), W'(6), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_sum",  sum,      '0);
    check("abort_cout", W'(cout), W'(0));
    check("abort_ovf",  W'(ovf),  W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", W'(done_seen), W'(0));

    // start pulsed in cycle 2 of RUN is ignored.
    @(negedge clk);
    drive_start(W'(3), W'(4), 1'b0);
    @(negedge clk);
    a      = W'(100);
    b      = W'(200);
    op_sub = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(3, lat, bcnt);
    check("ign_lat", W'(lat), W'(5));
    check("ign_sum", sum,     W'(7));

    // start held in the DONE cycle: back-to-back operation.
    @(negedge clk);
    drive_start(W'(10), W'(20), 1'b0);
    wait_done(1, lat, bcnt);
    check("b2b_first_lat", W'(lat), W'(5));
    check("b2b_first_sum", sum,     W'(30));
    drive_start(W'(1), W'(2), 1'b0);
    wait_done(1, lat, bcnt);
    check("b2b_second_lat",  W'(lat),  W'(5));
    check("b2b_second_busy", W'(bcnt), W'(4));
    check("b2b_second_sum",  sum,      W'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cla_limb_sequencer
